word_demux4: RTL and testbench
==============================

# word_demux4

Registered 1-to-4 word demultiplexer with a 2-entry buffer per destination channel. It takes 16-bit words from one shared result bus, each tagged with a 2-bit destination select, and steers each word to one of four consumer channels with independent valid/ready flow control. It is the write-back counterpart of the 4:1 word selection mux in the routing datapath: the mux gathers stage results onto the bus, and this block distributes bus words back to per-stage consumers. Per-channel buffering means one stalled consumer does not block words bound for the other channels.

## Interface
- WORD_WIDTH, 16, data word width
- clk  input  1  system clock; all state updates on the rising edge
- nrst  input  1  reset; asynchronous assertion, active-low
- in_valid  input  1  producer has a word on in_data
- in_ready  output  1  the selected channel can accept the word this cycle
- in_select  input  2  destination channel 0..3; meaningful only while in_valid=1
- in_data  input  WORD_WIDTH  word to deliver
- out_valid  output  4  bit k: channel k buffer non-empty
- out_ready  input  4  bit k: consumer k takes its head word this cycle
- out_data0..out_data3  output  WORD_WIDTH each  head word of channel k
- ch_full  output  4  bit k: channel k holds 2 words

## Operation
- Each channel k is a 2-entry FIFO: storage mem_k[0:1], 1-bit wr_ptr_k, 1-bit rd_ptr_k, 2-bit count_k with range 0..2.
- Push: in_valid & in_ready. The word is written to mem_sel[wr_ptr_sel], wr_ptr_sel toggles, and count_sel increments.
- Pop on channel k: out_valid[k] & out_ready[k]. rd_ptr_k toggles and count_k decrements. Pops on different channels are independent and may occur in the same cycle.
- in_ready = (count[in_select] != 2). It is combinational from in_select and registered counts only, with no dependence on out_ready, so there is no ready-to-ready path.
- A push and a pop on the same channel in the same cycle are both performed. count is unchanged, and both pointers advance.
- A push into the channel that is being popped while that channel is full is not possible, because in_ready is 0.
- out_valid[k] = (count_k != 0).
- out_data_k = mem_k[rd_ptr_k]. The value is driven from registers and is undefined-free: it reads 0 when the channel is empty after reset.
- ch_full[k] = (count_k == 2).
- Pointer wrap: 1-bit pointers wrap naturally, 1→0.
- in_select is ignored when in_valid=0. A push with in_ready=0 is not a transfer: the producer must hold in_valid, in_select and in_data until in_ready=1.
- No word is ever dropped, duplicated or reordered within a channel. Ordering across channels is not defined.

## Timing
- Reset, asynchronous on nrst=0:
  - all count_k = 0, pointers = 0, mem cleared to 0
  - out_valid = 4'b0000, out_data0..3 = 0, ch_full = 0
  - in_ready = 1
- Reset mid-operation discards all buffered words immediately, without waiting for a clock edge. Deassertion of nrst takes effect at the next rising edge of clk.
- Latency: a word pushed at edge N gives out_valid[k]=1 and out_data_k = that word after edge N, so it is visible in cycle N+1.
- Throughput: 1 word/cycle to any channel whose consumer holds out_ready=1 continuously.
- A channel with out_ready=0 fills after 2 pushes. From then on, in_ready=0 whenever in_select selects it.
- A pop at edge N frees space, and in_ready for that channel returns to 1 in cycle N+1.

## Test plan
- Reset/idle:
  - Stimulus: assert nrst=0 mid-traffic, then release.
  - Required response: out_valid=0000, ch_full=0000, all out_data=0, in_ready=1 with in_valid=0.
- Routing:
  - Stimulus: push 0x1111 sel0, 0x2222 sel1, 0x3333 sel2, 0x4444 sel3 in consecutive cycles with out_ready=1111.
  - Required response: each word appears only on its own channel, 1 cycle after its push, for exactly 1 cycle.
- Full/backpressure:
  - Stimulus: with out_ready[2]=0, push 0xA001, 0xA002, 0xA003 to sel2.
  - Required response:
    - ch_full[2]=1 after the second push; in_ready=0 while the third push is held.
    - Raising out_ready[2] pops 0xA001; 0xA003 is then accepted next cycle.
    - Drained order is A001, A002, A003.
- Simultaneous push/pop:
  - Stimulus: channel 1 holds 1 word (0x0B01), out_ready[1]=1, push 0x0B02 to sel1 in the same cycle.
  - Required response: count stays 1, and out_data1 becomes 0x0B02 the next cycle.
- Isolation and wrap:
  - Stimulus: channel 0 stalled full while 8 words stream to sel3 with out_ready[3]=1.
  - Required response: all 8 are delivered in order (pointers wrap 4 times), and channel 0 contents are unchanged.

Source files
------------

// File: rtl/word_demux4.sv
// rtl/word_demux4.sv - registered 1-to-4 word demultiplexer with 2-entry buffer per channel
module word_demux4 #(
    parameter int WORD_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_select,
    input  logic [WORD_WIDTH-1:0] in_data,
    output logic [3:0]            out_valid,
    input  logic [3:0]            out_ready,
    output logic [WORD_WIDTH-1:0] out_data0,
    output logic [WORD_WIDTH-1:0] out_data1,
    output logic [WORD_WIDTH-1:0] out_data2,
    output logic [WORD_WIDTH-1:0] out_data3,
    output logic [3:0]            ch_full
);

    logic [WORD_WIDTH-1:0] mem_q    [4][2];
    logic [WORD_WIDTH-1:0] mem_d    [4][2];
    logic                  wr_ptr_q [4];
    logic                  wr_ptr_d [4];
    logic                  rd_ptr_q [4];
    logic                  rd_ptr_d [4];
    logic [1:0]            count_q  [4];
    logic [1:0]            count_d  [4];
    logic                  push;

    // Ready depends only on the selected channel's registered count, never on out_ready
    assign in_ready = (count_q[in_select] != 2'd2);
    assign push     = in_valid & in_ready;

    // Per-channel status and head word, all taken straight from registers
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            out_valid[k] = (count_q[k] != 2'd0);
            ch_full[k]   = (count_q[k] == 2'd2);
        end
    end

    assign out_data0 = mem_q[0][rd_ptr_q[0]];
    assign out_data1 = mem_q[1][rd_ptr_q[1]];
    assign out_data2 = mem_q[2][rd_ptr_q[2]];
    assign out_data3 = mem_q[3][rd_ptr_q[3]];

    // Next state: steer the push to the selected FIFO, pop every channel independently
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        for (int k = 0; k < 4; k++) begin
            logic push_k;
            logic pop_k;
            push_k = push && (in_select == 2'(k));
            pop_k  = out_valid[k] & out_ready[k];
            if (push_k) begin
                mem_d[k][wr_ptr_q[k]] = in_data;
                wr_ptr_d[k]           = ~wr_ptr_q[k];
            end
            if (pop_k) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end
            count_d[k] = count_q[k] + 2'(push_k) - 2'(pop_k);
        end
    end

    // State registers; reset clears storage so empty channels read zero
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            for (int k = 0; k < 4; k++) begin
                mem_q[k][0] <= '0;
                mem_q[k][1] <= '0;
                wr_ptr_q[k] <= 1'b0;
                rd_ptr_q[k] <= 1'b0;
                count_q[k]  <= 2'd0;
            end
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_word_demux4.sv
// tb/tb_word_demux4.sv - self-checking bench for word_demux4
module tb_word_demux4;

    logic        clk = 1'b0;
    logic        nrst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_select;
    logic [15:0] in_data;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [15:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]  ch_full;
    logic [15:0] od [4];

    int checks = 0;
    int errors = 0;

    logic [15:0] mq [4][$];
    int          pops3;

    always #5 clk = ~clk;

    word_demux4 #(.WORD_WIDTH(16)) dut (
        .clk(clk), .nrst(nrst),
        .in_valid(in_valid), .in_ready(in_ready), .in_select(in_select), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
        .ch_full(ch_full)
    );

    assign od[0] = out_data0;
    assign od[1] = out_data1;
    assign od[2] = out_data2;
    assign od[3] = out_data3;

    typedef struct {
        logic        v;
        logic [1:0]  s;
        logic [15:0] d;
        logic [3:0]  r;
        logic        e_rdy;
        logic [3:0]  e_val;
        logic [3:0]  e_full;
        logic [1:0]  e_ch;
        logic [15:0] e_word;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Apply inputs and compare the pre-edge outputs with the queue model
    task automatic drive(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [3:0] r);
        logic [3:0] ev, ef;
        in_valid = v; in_select = s; in_data = d; out_ready = r;
        #1;
        for (int k = 0; k < 4; k++) begin
            ev[k] = (mq[k].size() != 0);
            ef[k] = (mq[k].size() == 2);
        end
        chk("model_in_ready", 32'(in_ready), 32'(mq[s].size() != 2));
        chk("model_out_valid", 32'(out_valid), 32'(ev));
        chk("model_ch_full", 32'(ch_full), 32'(ef));
        for (int k = 0; k < 4; k++)
            if (mq[k].size() != 0) chk($sformatf("model_out_data%0d", k), 32'(od[k]), 32'(mq[k][0]));
    endtask

    // Clock edge: update the model from the transfers that the edge performs
    task automatic advance(output logic pushed);
        logic       do_push;
        logic [3:0] do_pop;
        do_push = in_valid && (mq[in_select].size() != 2);
        for (int k = 0; k < 4; k++) do_pop[k] = out_ready[k] && (mq[k].size() != 0);
        @(posedge clk);
        for (int k = 0; k < 4; k++)
            if (do_pop[k]) begin
                void'(mq[k].pop_front());
                if (k == 3) pops3++;
            end
        if (do_push) mq[in_select].push_back(in_data);
        pushed = do_push;
        @(negedge clk);
    endtask

    task automatic cycle(input logic v, input logic [1:0] s, input logic [15:0] d, input logic [3:0] r);
        logic p;
        drive(v, s, d, r);
        advance(p);
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_ch_full"}, 32'(ch_full), 32'h0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h1);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_out_data%0d", tag, k), 32'(od[k]), 32'h0);
    endtask

    initial begin
        logic        p, hv;
        logic [1:0]  hs;
        logic [15:0] hd;

        // routing: one word per channel, every consumer ready
        tbl[0]  = '{1'b1, 2'd0, 16'h1111, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 16'h0000};
        tbl[1]  = '{1'b1, 2'd1, 16'h2222, 4'b1111, 1'b1, 4'b0001, 4'b0000, 2'd0, 16'h1111};
        tbl[2]  = '{1'b1, 2'd2, 16'h3333, 4'b1111, 1'b1, 4'b0010, 4'b0000, 2'd1, 16'h2222};
        tbl[3]  = '{1'b1, 2'd3, 16'h4444, 4'b1111, 1'b1, 4'b0100, 4'b0000, 2'd2, 16'h3333};
        tbl[4]  = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b1000, 4'b0000, 2'd3, 16'h4444};
        tbl[5]  = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 16'h0000};
        // backpressure on channel 2
        tbl[6]  = '{1'b1, 2'd2, 16'hA001, 4'b1011, 1'b1, 4'b0000, 4'b0000, 2'd0, 16'h0000};
        tbl[7]  = '{1'b1, 2'd2, 16'hA002, 4'b1011, 1'b1, 4'b0100, 4'b0000, 2'd2, 16'hA001};
        tbl[8]  = '{1'b1, 2'd2, 16'hA003, 4'b1011, 1'b0, 4'b0100, 4'b0100, 2'd2, 16'hA001};
        tbl[9]  = '{1'b1, 2'd2, 16'hA003, 4'b1111, 1'b0, 4'b0100, 4'b0100, 2'd2, 16'hA001};
        tbl[10] = '{1'b1, 2'd2, 16'hA003, 4'b1111, 1'b1, 4'b0100, 4'b0000, 2'd2, 16'hA002};
        tbl[11] = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0100, 4'b0000, 2'd2, 16'hA003};
        tbl[12] = '{1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000, 4'b0000, 2'd0, 16'h0000};

        nrst = 1'b0; in_valid = 1'b0; in_select = 2'd0; in_data = 16'h0; out_ready = 4'h0;
        pops3 = 0;
        repeat (3) @(negedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r);
            chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_val));
            chk($sformatf("vec%0d_ch_full", i), 32'(ch_full), 32'(tbl[i].e_full));
            if (tbl[i].e_val != 4'b0000)
                chk($sformatf("vec%0d_out_data", i), 32'(od[tbl[i].e_ch]), 32'(tbl[i].e_word));
            advance(p);
        end

        // simultaneous push and pop on channel 1
        cycle(1'b1, 2'd1, 16'h0B01, 4'b0000);
        drive(1'b1, 2'd1, 16'h0B02, 4'b0010);
        chk("pp_head_before", 32'(out_data1), 32'h0B01);
        advance(p);
        chk("pp_pushed", 32'(p), 32'h1);
        drive(1'b0, 2'd0, 16'h0, 4'b0000);
        chk("pp_valid1", 32'(out_valid[1]), 32'h1);
        chk("pp_not_full1", 32'(ch_full[1]), 32'h0);
        chk("pp_head_after", 32'(out_data1), 32'h0B02);
        advance(p);
        cycle(1'b0, 2'd0, 16'h0, 4'b1111);

        // isolation and pointer wrap: channel 0 stalled full, 8 words stream to channel 3
        cycle(1'b1, 2'd0, 16'hC001, 4'b0000);
        cycle(1'b1, 2'd0, 16'hC002, 4'b0000);
        pops3 = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'd3, 16'hD000 + 16'(i), 4'b1000);
            chk($sformatf("iso_ready%0d", i), 32'(in_ready), 32'h1);
            advance(p);
        end
        cycle(1'b0, 2'd0, 16'h0, 4'b1000);
        chk("iso_delivered", 32'(pops3), 32'd8);
        chk("iso_ch0_full", 32'(ch_full[0]), 32'h1);
        chk("iso_ch0_head", 32'(out_data0), 32'hC001);
        drive(1'b1, 2'd0, 16'hC003, 4'b0000);
        chk("iso_ch0_blocked", 32'(in_ready), 32'h0);
        advance(p);
        cycle(1'b0, 2'd0, 16'h0, 4'b1111);
        cycle(1'b0, 2'd0, 16'h0, 4'b1111);

        // randomized traffic; producer holds a refused word until accepted
        hv = 1'b0; hs = 2'd0; hd = 16'h0;
        for (int i = 0; i < 400; i++) begin
            if (!hv) begin
                hv = ($urandom_range(0, 3) != 0);
                hs = 2'($urandom_range(0, 3));
                hd = 16'($urandom_range(0, 16'hFFFF));
            end
            drive(hv, hs, hd, 4'($urandom_range(0, 15)));
            advance(p);
            if (p) hv = 1'b0;
        end

        // reset mid-traffic, asserted between edges
        cycle(1'b1, 2'd1, 16'hE001, 4'b0000);
        cycle(1'b1, 2'd2, 16'hE002, 4'b0000);
        #2;
        nrst = 1'b0;
        in_valid = 1'b0; in_select = 2'd1;
        #1;
        check_reset_state("midreset");
        for (int k = 0; k < 4; k++) mq[k].delete();
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        cycle(1'b1, 2'd3, 16'h5A5A, 4'b0000);
        drive(1'b0, 2'd0, 16'h0, 4'b0000);
        chk("post_reset_head3", 32'(out_data3), 32'h5A5A);
        advance(p);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
